// File: rtl/apb4_mem_ws.sv
// APB4 memory slave with byte strobes, selectable wait-state generation and
// PSLVERR reporting for range, alignment, read-only and privilege violations.
module apb4_mem_ws #(
    parameter int              DATA_WIDTH  = 32,
    parameter int              ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int              SIZE_BYTES  = 4096,
    parameter int              RO_BYTES    = 0,
    parameter bit              PRIV_ONLY   = 1'b0,
    parameter int              WAIT_MODE   = 0,
    parameter int              WAIT_CYCLES = 2,
    parameter logic [3:0]      WAIT_MASK   = 4'h3,
    parameter logic [7:0]      LFSR_SEED   = 8'hA5
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    input  logic                      PWRITE,
    input  logic [ADDR_WIDTH-1:0]     PADDR,
    input  logic [DATA_WIDTH-1:0]     PWDATA,
    input  logic [DATA_WIDTH/8-1:0]   PSTRB,
    input  logic [2:0]                PPROT,
    output logic [DATA_WIDTH-1:0]     PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic [15:0]               err_count
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int BYTE_LSB = $clog2(STRB_W);
    localparam int DEPTH    = SIZE_BYTES / STRB_W;
    localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] SIZE_L = (ADDR_WIDTH + 1)'(SIZE_BYTES);
    localparam logic [ADDR_WIDTH:0] RO_L   = (ADDR_WIDTH + 1)'(RO_BYTES);
    localparam logic [7:0] LFSR_INIT = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    // Handshake: a transfer is a setup cycle (PSEL=1, PENABLE=0) followed by
    // access cycles (PSEL=1, PENABLE=1); it completes on the first access
    // cycle with PREADY=1, and PSLVERR is only meaningful in that cycle.

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [7:0]            wcnt_q, wcnt_d;
    logic                  err_q, err_d;
    logic [7:0]            lfsr_q, lfsr_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic [15:0]           err_count_q, err_count_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    logic [ADDR_WIDTH-1:0] offset;
    logic [IDX_W-1:0]      idx;
    logic                  err_now;
    logic [7:0]            wait_load;
    logic [7:0]            lfsr_next;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  unused_prot;

    assign offset      = PADDR - BASE_ADDR;
    assign idx         = offset[BYTE_LSB +: IDX_W];
    assign unused_prot = ^PPROT[2:1];

    assign err_now = ({1'b0, offset} >= SIZE_L)
                   | (PADDR[BYTE_LSB-1:0] != '0)
                   | (PWRITE & ({1'b0, offset} < RO_L))
                   | (PRIV_ONLY & ~PPROT[0]);

    assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_comb begin
        wait_load = 8'd0;
        case (WAIT_MODE)
            1:       wait_load = 8'(WAIT_CYCLES);
            2:       wait_load = {4'd0, lfsr_q[3:0] & WAIT_MASK};
            default: wait_load = 8'd0;
        endcase
    end

    assign PREADY    = (wcnt_q == 8'd0);
    assign PSLVERR   = err_q & PREADY & PSEL & PENABLE;
    assign PRDATA    = prdata_q;
    assign err_count = err_count_q;

    always_comb begin
        wcnt_d      = wcnt_q;
        err_d       = err_q;
        lfsr_d      = lfsr_q;
        prdata_d    = prdata_q;
        err_count_d = err_count_q;
        idx_d       = idx_q;
        if (!PSEL) begin
            // Idle, or the master dropped PSEL mid-transfer: abandon it.
            wcnt_d = 8'd0;
            err_d  = 1'b0;
        end else if (!PENABLE) begin
            err_d  = err_now;
            wcnt_d = wait_load;
            lfsr_d = lfsr_next;
            idx_d  = idx;
            if (!PWRITE) begin
                prdata_d = err_now ? '0 : mem_q[idx];
            end
        end else if (wcnt_q != 8'd0) begin
            wcnt_d = wcnt_q - 8'd1;
        end else if (err_q && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    // Strobed lanes take write data, the rest keep the stored word.
    always_comb begin
        mem_wdata = mem_q[idx_q];
        for (int i = 0; i < STRB_W; i++) begin
            if (PSTRB[i]) begin
                mem_wdata[8*i +: 8] = PWDATA[8*i +: 8];
            end
        end
    end

    assign mem_we = PRESETn & PSEL & PENABLE & PREADY & PWRITE & ~err_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wcnt_q      <= 8'd0;
            err_q       <= 1'b0;
            lfsr_q      <= LFSR_INIT;
            prdata_q    <= '0;
            err_count_q <= 16'd0;
            idx_q       <= '0;
        end else begin
            wcnt_q      <= wcnt_d;
            err_q       <= err_d;
            lfsr_q      <= lfsr_d;
            prdata_q    <= prdata_d;
            err_count_q <= err_count_d;
            idx_q       <= idx_d;
        end
    end

    // Storage survives reset so data written before a reset can be read back.
    always_ff @(posedge PCLK) begin
        if (mem_we) begin
            mem_q[idx_q] <= mem_wdata;
        end
    end

endmodule
